// File: rtl/aes128_dec_seq.sv
// Iterative AES-128 decryptor: one key-expansion step or one inverse round per clock,
// with an 11-entry round-key store and valid/ready handshakes on both sides.
module aes128_dec_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         key_ok,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, FINAL} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          key_ok_q;
    logic          out_valid_q;
    logic [127:0]  out_data_q;
    logic [127:0]  st_q;
    logic [127:0]  rk_q [0:10];

    logic [3:0]    prev_idx_d;
    logic [127:0]  rk_prev_d;
    logic [127:0]  rk_sel_d;
    logic [127:0]  key_next_d;
    logic [127:0]  isr_d;
    logic [127:0]  isb_d;
    logic [127:0]  ark_d;
    logic [127:0]  imc_d;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = x;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] d;
        d = {x, x} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = ginv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // Byte 0 sits in bits [127:120]; bytes fill the state column by column.
    function automatic logic [7:0] byte_of(input logic [127:0] x, input int b);
        return x[127-8*b -: 8];
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = byte_of(s, 4*((c - r + 4) % 4) + r);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++) begin
            o[127-8*b -: 8] = inv_sbox(byte_of(s, b));
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = byte_of(s, 4*c);
            a1 = byte_of(s, 4*c+1);
            a2 = byte_of(s, 4*c+2);
            a3 = byte_of(s, 4*c+3);
            o[127-32*c -: 8]  = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8]  = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [31:0] rcon);
        logic [31:0] w3;
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rcon;
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        return {n0, n1, n2, w3 ^ n2};
    endfunction

    function automatic logic [31:0] rcon_of(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return {r, 24'h000000};
    endfunction

    // Shared datapath: ROUND uses rk[cnt] then InvMixColumns, FINAL reaches cnt=0 and uses rk[0].
    always_comb begin
        prev_idx_d = cnt_q - 4'd1;
        rk_prev_d  = (prev_idx_d <= 4'd10) ? rk_q[prev_idx_d] : '0;
        rk_sel_d   = (cnt_q <= 4'd10) ? rk_q[cnt_q] : '0;
        key_next_d = key_expansion(rk_prev_d, rcon_of(cnt_q));
        isr_d      = inv_shift_rows(st_q);
        isb_d      = inv_sub_bytes(isr_d);
        ark_d      = isb_d ^ rk_sel_d;
        imc_d      = inv_mix_columns(ark_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            key_ok_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            st_q        <= '0;
            for (int i = 0; i <= 10; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (key_load) begin
                        rk_q[0]  <= key_in;
                        key_ok_q <= 1'b0;
                        cnt_q    <= 4'd1;
                        state_q  <= KEXP;
                    end else if (in_valid && in_ready) begin
                        st_q    <= in_data ^ rk_q[10];
                        cnt_q   <= 4'd9;
                        state_q <= ROUND;
                    end
                end
                KEXP: begin
                    rk_q[cnt_q] <= key_next_d;
                    if (cnt_q == 4'd10) begin
                        key_ok_q <= 1'b1;
                        cnt_q    <= 4'd0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    st_q  <= imc_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    out_data_q  <= ark_d;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign key_ok    = key_ok_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign in_ready  = (state_q == IDLE) & key_ok_q & ~out_valid_q & ~key_load;

endmodule

// File: tb/tb_aes128_dec_seq.sv
// Directed bench for aes128_dec_seq using the FIPS-197 example vectors.
module tb_aes128_dec_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready;
    logic         key_ok;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes128_dec_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_ok    (key_ok),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses key_load and returns the number of edges until key_ok rises (40 = timed out).
    task automatic load_key(input logic [127:0] k, output int cyc);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
        cyc = 0;
        while (!key_ok && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Offers one block, returns wait-for-ready, latency from accept edge and busy-cycle count.
    task automatic run_block(input logic [127:0] ct, output int wait_in, output int lat, output int busy_cyc);
        in_valid = 1'b1;
        in_data  = ct;
        #1;
        wait_in = 0;
        while (!in_ready && wait_in < 40) begin
            tick();
            wait_in++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        busy_cyc = busy ? 1 : 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = CT_A;
        repeat (2) tick();
        checks++; if (key_ok !== 1'b0) begin errors++; $display("FAIL reset_key_ok: got %b expected 0", key_ok); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nokey_in_ready: got %b expected 0", in_ready); end
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nokey_busy: got %b expected 0", busy); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_key_expansion();
        int cyc;
        load_key(KEY_A, cyc);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL kexp_cycles_A: got %0d expected 10", cyc); end
        checks++; if (dut.rk_q[10] !== RK10_A) begin errors++; $display("FAIL rk10_A: got %h expected %h", dut.rk_q[10], RK10_A); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL kexp_done_key_ready: got %b expected 1", key_ready); end
    endtask

    task automatic test_decrypt_basic();
        int w, lat, bc;
        out_ready = 1'b1;
        run_block(CT_A, w, lat, bc);
        checks++; if (w !== 0) begin errors++; $display("FAIL basic_wait_in: got %0d expected 0", w); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency: got %0d expected 10", lat); end
        checks++; if (bc !== 10) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 10", bc); end
        checks++; if (out_data !== PT_A) begin errors++; $display("FAIL basic_pt_A: got %h expected %h", out_data, PT_A); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake: got %b expected 0", out_valid); end
    endtask

    task automatic test_second_key();
        int cyc, w, lat, bc;
        load_key(KEY_B, cyc);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL kexp_cycles_B: got %0d expected 10", cyc); end
        checks++; if (dut.rk_q[10] !== RK10_B) begin errors++; $display("FAIL rk10_B: got %h expected %h", dut.rk_q[10], RK10_B); end
        run_block(CT_B, w, lat, bc);
        checks++; if (lat !== 10) begin errors++; $display("FAIL keyB_latency: got %0d expected 10", lat); end
        checks++; if (out_data !== PT_B) begin errors++; $display("FAIL keyB_pt: got %h expected %h", out_data, PT_B); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL keyB_handshake: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int w, lat, bc;
        out_ready = 1'b0;
        run_block(CT_B, w, lat, bc);
        checks++; if (out_data !== PT_B) begin errors++; $display("FAIL bp_first_pt: got %h expected %h", out_data, PT_B); end
        in_valid = 1'b1;
        in_data  = CT_B;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== PT_B || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                         i, out_valid, in_ready, out_data, PT_B);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got busy=%b expected 1", busy); end
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 10) begin errors++; $display("FAIL bp_second_latency: got %0d expected 10", lat); end
        checks++; if (out_data !== PT_B) begin errors++; $display("FAIL bp_second_pt: got %h expected %h", out_data, PT_B); end
        run_block(CT_B, w, lat, bc);
        checks++; if (w !== 1) begin errors++; $display("FAIL b2b_wait_in: got %0d expected 1", w); end
        checks++; if (out_data !== PT_B) begin errors++; $display("FAIL b2b_pt: got %h expected %h", out_data, PT_B); end
        tick();
    endtask

    task automatic test_key_priority();
        int n, lat, cyc;
        out_ready = 1'b1;
        key_load  = 1'b1;
        key_in    = KEY_A;
        in_valid  = 1'b1;
        in_data   = CT_A;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL prio_in_ready: got %b expected 0", in_ready); end
        tick();
        key_load = 1'b0;
        checks++; if (busy !== 1'b1 || key_ok !== 1'b0) begin errors++; $display("FAIL prio_kexp: got busy=%b key_ok=%b expected busy=1 key_ok=0", busy, key_ok); end
        n = 0;
        while (!key_ok && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL prio_kexp_cycles: got %0d expected 10", n); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_held_block_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        out_ready = 1'b0;
        checks++; if (out_data !== PT_A) begin errors++; $display("FAIL prio_new_key_pt: got %h expected %h", out_data, PT_A); end
        load_key(KEY_B, cyc);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL pend_kexp_cycles: got %0d expected 10", cyc); end
        checks++; if (out_valid !== 1'b1 || out_data !== PT_A) begin errors++; $display("FAIL pend_output: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, PT_A); end
        checks++; if (dut.rk_q[10] !== RK10_B) begin errors++; $display("FAIL pend_rk10: got %h expected %h", dut.rk_q[10], RK10_B); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = CT_B;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        key_load = 1'b1;
        key_in   = KEY_A;
        #1;
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL round_key_ready: got %b expected 0", key_ready); end
        tick();
        key_load = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (out_data !== PT_B) begin errors++; $display("FAIL round_keyload_pt: got %h expected %h", out_data, PT_B); end
        checks++; if (dut.rk_q[10] !== RK10_B) begin errors++; $display("FAIL round_keyload_rk10: got %h expected %h", dut.rk_q[10], RK10_B); end
        tick();
    endtask

    task automatic test_reset_mid();
        int w, lat, bc, cyc;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = CT_B;
        #1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || key_ok !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got valid=%b key_ok=%b busy=%b expected 0 0 0", out_valid, key_ok, busy); end
        checks++; if (dut.rk_q[10] !== 128'h0) begin errors++; $display("FAIL midrst_rk10: got %h expected 0", dut.rk_q[10]); end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = CT_A;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        end
        in_valid = 1'b0;
        load_key(KEY_A, cyc);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL midrst_kexp_cycles: got %0d expected 10", cyc); end
        run_block(CT_A, w, lat, bc);
        checks++; if (lat !== 10) begin errors++; $display("FAIL midrst_latency: got %0d expected 10", lat); end
        checks++; if (out_data !== PT_A) begin errors++; $display("FAIL midrst_pt_A: got %h expected %h", out_data, PT_A); end
        tick();
    endtask

    initial begin
        test_reset();
        test_key_expansion();
        test_decrypt_basic();
        test_second_key();
        test_backpressure();
        test_key_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
